// File: rtl/muldiv_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_OPS = 8;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Even opcodes are the signed variants.
  function automatic logic op_signed(op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic                          Start;
  logic [$clog2(MULDIV_OPS)-1:0] Op;
  logic [WIDTH-1:0]              A;
  logic [WIDTH-1:0]              B;
  logic [WIDTH-1:0]              HiIn;
  logic [WIDTH-1:0]              LoIn;
  logic                          Cancel;
  logic                          Busy;
  logic                          Done;
  logic [WIDTH-1:0]              HiOut;
  logic [WIDTH-1:0]              LoOut;
  logic                          DivByZero;

  modport master (
    output Start, Op, A, B, HiIn, LoIn, Cancel,
    input  Busy, Done, HiOut, LoOut, DivByZero
  );

  modport slave (
    input  Start, Op, A, B, HiIn, LoIn, Cancel,
    output Busy, Done, HiOut, LoOut, DivByZero
  );

endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring divide on magnitudes.
// Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
// Divide:   hi is the partial remainder, lo shifts dividend out / quotient in.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Single-step datapath; diff[WIDTH] set means the trial subtract went negative
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO accumulate.
//   state   | meaning
//   IDLE    | waiting for Start, outputs hold last result
//   CALC    | WIDTH radix-2 steps on operand magnitudes
//   FIX     | sign correction / accumulate, result registered, Done next cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit ACCUM_EN = 1'b1
) (
  input logic     Clk,
  input logic     Rst,
  muldiv_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_in_q, hi_in_d, lo_in_q, lo_in_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   hi_out_q, hi_out_d, lo_out_q, lo_out_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  op_e                op_in;
  logic               a_neg_in, b_neg_in, a_neg_q, b_neg_q, div_q;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in, a_mag_q, b_mag_q;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, mul_res;
  logic [WIDTH-1:0]   quot, rem;

  // Signs and magnitudes of the incoming and the held operands
  always_comb begin
    op_in    = op_e'(bus.Op);
    a_neg_in = op_signed(op_in) & bus.A[WIDTH-1];
    b_neg_in = op_signed(op_in) & bus.B[WIDTH-1];
    a_mag_in = a_neg_in ? (~bus.A + 1'b1) : bus.A;
    b_mag_in = b_neg_in ? (~bus.B + 1'b1) : bus.B;
    a_neg_q  = op_signed(op_q) & a_q[WIDTH-1];
    b_neg_q  = op_signed(op_q) & b_q[WIDTH-1];
    a_mag_q  = a_neg_q ? (~a_q + 1'b1) : a_q;
    b_mag_q  = b_neg_q ? (~b_q + 1'b1) : b_q;
    div_q    = op_is_div(op_q);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div_mode (div_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .operand  (div_q ? b_mag_q : a_mag_q),
    .hi_nxt   (step_hi),
    .lo_nxt   (step_lo)
  );

  // Sign correction and HI/LO accumulate applied in FIX
  always_comb begin
    prod = {hi_q, lo_q};
    if (a_neg_q ^ b_neg_q) prod = ~prod + 1'b1;
    mul_res = prod;
    if (ACCUM_EN) begin
      case (op_q)
        OP_MADD, OP_MADDU: mul_res = {hi_in_q, lo_in_q} + prod;
        OP_MSUB, OP_MSUBU: mul_res = {hi_in_q, lo_in_q} - prod;
        default:           mul_res = prod;
      endcase
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // The most-negative / -1 case wraps to the right answer on its own.
    quot = (a_neg_q ^ b_neg_q) ? (~lo_q + 1'b1) : lo_q;
    rem  = a_neg_q ? (~hi_q + 1'b1) : hi_q;
  end

  // Next-state, working registers and result registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_in_d  = hi_in_q;
    lo_in_d  = lo_in_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_out_d = hi_out_q;
    lo_out_d = lo_out_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    if (bus.Cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            op_d    = op_in;
            a_d     = bus.A;
            b_d     = bus.B;
            hi_in_d = bus.HiIn;
            lo_in_d = bus.LoIn;
            hi_d    = '0;
            lo_d    = op_is_div(op_in) ? a_mag_in : b_mag_in;
          end
        end
        ST_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (div_q) begin
            if (b_q == '0) begin
              hi_out_d = a_q;
              lo_out_d = '1;
              dbz_d    = 1'b1;
            end else begin
              hi_out_d = rem;
              lo_out_d = quot;
            end
          end else begin
            hi_out_d = mul_res[2*WIDTH-1:WIDTH];
            lo_out_d = mul_res[WIDTH-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by Rst
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      hi_in_q  <= '0;
      lo_in_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_out_q <= '0;
      lo_out_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_in_q  <= hi_in_d;
      lo_in_q  <= lo_in_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_out_q <= hi_out_d;
      lo_out_q <= lo_out_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.HiOut     = hi_out_q;
  assign bus.LoOut     = lo_out_q;

endmodule
